// File: rtl/m_mem_stage.sv
// MIPS memory-access stage: load/store decode, req/ack handshake with a
// variable-latency data memory, load-lane extraction and pipeline stall.
module m_mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        validM,
   input  logic [31:0] instrM,
   input  logic        regwriteM_in,
   input  logic        memtoregM_in,
   input  logic [31:0] aluoutM_in,
   input  logic [31:0] writedataM,
   input  logic [4:0]  writeregM_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [29:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stallM,
   output logic        regwriteM,
   output logic        memtoregM,
   output logic [31:0] aluoutM,
   output logic [31:0] readdata,
   output logic [4:0]  writeregM,
   output logic [31:0] instrM_o,
   output logic [1:0]  memerrM
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23,
                          OP_LBU = 6'h24, OP_LHU = 6'h25,
                          OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

   stateT       state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic [1:0]  err, errNext;
   logic [31:0] capWord, capWordNext;
   logic        reqRaw;

   logic [5:0]  opcode;
   logic [1:0]  off;
   logic        isLoad, isStore, isByte, isHalf, isWord, memop, misaligned;
   logic [7:0]  selByte;
   logic [15:0] selHalf;

   assign opcode = instrM[31:26];
   assign off    = aluoutM_in[1:0];

   assign isLoad  = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                    (opcode == OP_LBU) || (opcode == OP_LHU);
   assign isStore = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   assign isByte  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
   assign isHalf  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
   assign isWord  = (opcode == OP_LW) || (opcode == OP_SW);
   assign memop   = validM & (isLoad | isStore);
   assign misaligned = (isHalf & off[0]) | (isWord & (off != 2'b00));

   assign dmem_addr  = aluoutM_in[31:2];
   assign dmem_we    = validM & isStore;
   // Stores replicate data across lanes; byte enables pick the live lane(s).
   assign dmem_wdata = isByte ? {4{writedataM[7:0]}} :
                       isHalf ? {2{writedataM[15:0]}} : writedataM;

   always_comb begin
      dmem_be = 4'b0000;
      if (memop) begin
         if (isStore && isByte)      dmem_be = 4'b0001 << off;
         else if (isStore && isHalf) dmem_be = off[1] ? 4'b1100 : 4'b0011;
         else                        dmem_be = 4'b1111;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      errNext     = err;
      capWordNext = capWord;
      reqRaw      = 1'b0;
      stallM      = 1'b0;
      unique case (state)
         IDLE: begin
            if (memop) begin
               stallM = 1'b1;
               if (misaligned) begin
                  stateNext   = DONE;
                  errNext     = 2'b01;
                  capWordNext = '0;
               end else begin
                  reqRaw = 1'b1;
                  if (dmem_ack) begin
                     stateNext   = DONE;
                     errNext     = 2'b00;
                     capWordNext = dmem_rdata;
                  end else begin
                     stateNext = WAIT;
                     cntNext   = CW'(1);
                  end
               end
            end
         end
         WAIT: begin
            reqRaw = 1'b1;
            stallM = 1'b1;
            // An ack in the final allowed cycle still wins over the timeout.
            if (dmem_ack) begin
               stateNext   = DONE;
               errNext     = 2'b00;
               capWordNext = dmem_rdata;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               stateNext   = DONE;
               errNext     = 2'b10;
               capWordNext = '0;
            end else begin
               cntNext = cnt + CW'(1);
            end
         end
         DONE: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Request is masked while reset is held so it drops the instant rst_n falls.
   assign dmem_req = reqRaw & rst_n;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         err     <= 2'b00;
         capWord <= '0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         err     <= errNext;
         capWord <= capWordNext;
      end
   end

   assign selByte = capWord[{off, 3'b000} +: 8];
   assign selHalf = capWord[{off[1], 4'b0000} +: 16];

   always_comb begin
      readdata = '0;
      if (state == DONE && validM && isLoad) begin
         unique case (opcode)
            OP_LB:   readdata = {{24{selByte[7]}}, selByte};
            OP_LBU:  readdata = {24'h0, selByte};
            OP_LH:   readdata = {{16{selHalf[15]}}, selHalf};
            OP_LHU:  readdata = {16'h0, selHalf};
            default: readdata = capWord;
         endcase
      end
   end

   assign memerrM   = (state == DONE) ? err : 2'b00;
   assign regwriteM = regwriteM_in & validM & ((state == DONE) ? (err == 2'b00) : 1'b1);
   assign memtoregM = memtoregM_in & validM;
   assign aluoutM   = aluoutM_in;
   assign writeregM = writeregM_in;
   assign instrM_o  = instrM;

endmodule

// File: tb/tb_m_mem_stage.sv
// Scoreboard bench for m_mem_stage: expectations are queued when an op is
// driven and popped when the stage releases the stall.
module tb_m_mem_stage;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        validM;
   logic [31:0] instrM;
   logic        regwriteM_in, memtoregM_in;
   logic [31:0] aluoutM_in, writedataM;
   logic [4:0]  writeregM_in;
   logic        dmem_req, dmem_we;
   logic [29:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stallM, regwriteM, memtoregM;
   logic [31:0] aluoutM, readdata, instrM_o;
   logic [4:0]  writeregM;
   logic [1:0]  memerrM;

   m_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .validM(validM), .instrM(instrM),
      .regwriteM_in(regwriteM_in), .memtoregM_in(memtoregM_in),
      .aluoutM_in(aluoutM_in), .writedataM(writedataM), .writeregM_in(writeregM_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .stallM(stallM), .regwriteM(regwriteM),
      .memtoregM(memtoregM), .aluoutM(aluoutM), .readdata(readdata),
      .writeregM(writeregM), .instrM_o(instrM_o), .memerrM(memerrM)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        chkRd;
      logic        rw, mt;
      logic [1:0]  err;
      int          stalls, reqs;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [29:0] addr;
   } expT;

   expT sb[$];
   int  nChecks = 0;
   int  nFails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ldExt(input logic [5:0] op, input logic [1:0] off,
                                         input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (op)
         6'h20:   return {{24{sh[7]}}, sh[7:0]};
         6'h24:   return {24'h0, sh[7:0]};
         6'h21:   return {{16{sh[15]}}, sh[15:0]};
         6'h25:   return {16'h0, sh[15:0]};
         6'h23:   return w;
         default: return 32'h0;
      endcase
   endfunction

   function automatic expT model(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rdata,
                                 input int ackOn, input logic valid);
      expT e;
      logic isL, isS, mis;
      logic [1:0] off;
      off = addr[1:0];
      isL = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
      isS = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
      mis = (((op == 6'h21) || (op == 6'h25) || (op == 6'h29)) && off[0]) ||
            (((op == 6'h23) || (op == 6'h2B)) && (off != 2'b00));
      e.rd = 32'h0; e.chkRd = 1'b1; e.err = 2'b00; e.stalls = 0; e.reqs = 0;
      e.addr = addr[31:2]; e.we = isS;
      case (op)
         6'h28:   begin e.be = 4'b0001 << off; e.wdata = {4{wd[7:0]}}; end
         6'h29:   begin e.be = off[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}}; end
         default: begin e.be = 4'b1111; e.wdata = wd; end
      endcase
      if (valid && (isL || isS)) begin
         if (mis) begin
            e.err = 2'b01; e.stalls = 1; e.chkRd = 1'b0;
         end else if (ackOn >= 1 && ackOn <= TIMEOUT) begin
            e.reqs = ackOn; e.stalls = ackOn;
            e.rd = isL ? ldExt(op, off, rdata) : 32'h0;
         end else begin
            e.reqs = TIMEOUT; e.stalls = TIMEOUT; e.err = 2'b10;
         end
      end
      e.rw = valid && (e.err == 2'b00);
      e.mt = valid && isL;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the edge that ends the op.
   task automatic runOp(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ackOn, input logic valid);
      expT e;
      int stalls, reqs;
      bit done, firstReq;
      logic isL;
      isL = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
      sb.push_back(model(op, addr, wd, rdata, ackOn, valid));
      validM       = valid;
      instrM       = {op, 26'(($urandom & 32'h03FF_FFFF))};
      regwriteM_in = 1'b1;
      memtoregM_in = isL;
      aluoutM_in   = addr;
      writedataM   = wd;
      writeregM_in = 5'($urandom_range(1, 31));
      stalls = 0; reqs = 0; done = 0; firstReq = 1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!stallM) begin
            e = sb.pop_front();
            check("stall_cycles", stalls, e.stalls);
            check("req_cycles", reqs, e.reqs);
            check("memerrM", memerrM, e.err);
            check("regwriteM", regwriteM, e.rw);
            check("memtoregM", memtoregM, e.mt);
            if (e.chkRd) check("readdata", readdata, e.rd);
            check("aluoutM", aluoutM, aluoutM_in);
            check("writeregM", writeregM, writeregM_in);
            check("instrM_o", instrM_o, instrM);
            check("req_in_done", dmem_req, 1'b0);
            done = 1;
         end else begin
            stalls++;
            if (dmem_req) begin
               reqs++;
               if (firstReq) begin
                  e = sb[0];
                  check("dmem_addr", dmem_addr, e.addr);
                  check("dmem_we", dmem_we, e.we);
                  check("dmem_be", dmem_be, e.be);
                  if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
                  firstReq = 0;
               end
               dmem_ack   = (reqs == ackOn);
               dmem_rdata = rdata;
            end
         end
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
      end
      if (!done) begin
         check("op_completion_bound", 0, 1);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      validM = 1'b1; instrM = {6'h23, 26'h0}; regwriteM_in = 1'b1; memtoregM_in = 1'b1;
      aluoutM_in = 32'h100; writedataM = 32'h0; writeregM_in = 5'd3;
      #2;
      check("reset_req", dmem_req, 1'b0);
      check("reset_memerr", memerrM, 2'b00);
      validM = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      runOp(6'h00, 32'h0000_1234, 32'h5, 32'h0, 0, 1'b1);          // add: pass-through
      runOp(6'h23, 32'h0000_0100, 32'h0, 32'h1122_3344, 3, 1'b1);  // lw, ack on 3rd
      runOp(6'h20, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1, 1'b1);  // lb
      runOp(6'h24, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 1'b1);  // lbu
      runOp(6'h25, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1, 1'b1);  // lhu
      runOp(6'h21, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1, 1'b1);  // lh
      runOp(6'h28, 32'h0000_0202, 32'h0000_00AB, 32'h0, 1, 1'b1);  // sb
      runOp(6'h29, 32'h0000_0102, 32'h0000_1234, 32'h0, 2, 1'b1);  // sh
      runOp(6'h2B, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 1, 1'b1);  // sw
      runOp(6'h29, 32'h0000_0101, 32'h0000_1234, 32'h0, 1, 1'b1);  // sh misaligned
      runOp(6'h23, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 1, 1'b1);  // lw misaligned
      runOp(6'h23, 32'h0000_0180, 32'h0, 32'h5555_AAAA, 0, 1'b1);  // lw timeout
      runOp(6'h23, 32'h0000_0180, 32'h0, 32'h5555_AAAA, TIMEOUT, 1'b1); // ack in last cycle
      runOp(6'h23, 32'h0000_0180, 32'h0, 32'h5555_AAAA, 1, 1'b0);  // invalid slot

      // Reset asserted while waiting on the memory.
      validM = 1'b1; instrM = {6'h23, 26'h0}; aluoutM_in = 32'h300; memtoregM_in = 1'b1;
      @(negedge clk);
      check("rst_wait_req_idle", dmem_req, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_wait_req_wait", dmem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", dmem_req, 1'b0);
      check("rst_mid_memerr", memerrM, 2'b00);
      validM = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_stall", stallM, 1'b0);
      check("post_rst_memerr", memerrM, 2'b00);
      @(posedge clk); #1;

      runOp(6'h20, 32'h0000_0101, 32'h0, 32'h0000_7F00, 1, 1'b1);  // lb after reset
      runOp(6'h29, 32'h0000_0100, 32'h0000_BEEF, 32'h0, 5, 1'b1);  // sh timeout
      runOp(6'h25, 32'h0000_0100, 32'h0, 32'h1234_F00D, 2, 1'b1);  // lhu low half

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/m_mem_stage.md
# m_mem_stage

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. It decodes load/store opcodes and runs a request/acknowledge transaction with a variable-latency data memory. It aligns and extends load data, and stalls the pipeline until the access completes. Its outputs feed the MEM/WB register directly; misaligned accesses and memory timeouts are reported as error codes.

## Interface
- TIMEOUT, 16: maximum number of request cycles before the access is aborted (≥2).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- validM  in  1  EX/MEM slot holds a real instruction.
- instrM  in  32  instruction word; bits 31:26 are the opcode.
- regwriteM_in, memtoregM_in  in  1 each  control bits from EX/MEM.
- aluoutM_in  in  32  ALU result; this is the effective address for loads and stores.
- writedataM  in  32  store data (rt value).
- writeregM_in  in  5  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable.
- dmem_addr  out  30  word address = aluoutM_in[31:2].
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated write data.
- dmem_ack  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  read word; valid when dmem_ack=1.
- stallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; holds MEM/WB from capturing a bubble.
- regwriteM, memtoregM  out  1 each  to MEM/WB.
- aluoutM  out  32  to MEM/WB.
- readdata  out  32  extended load data, to MEM/WB.
- writeregM  out  5  to MEM/WB.
- instrM_o  out  32  to MEM/WB.
- memerrM  out  2  error code: 00 none, 01 misaligned, 10 timeout.

## Operation
- **Opcode decode:**
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - memop = validM & (load | store).
- **Byte lanes:** little-endian. Byte offset off = aluoutM_in[1:0]; lane k = bits 8k+7:8k.
- **Misalignment:** half access with off[0]=1, or word access with off≠0.
- **Byte enables:** sb → 1<<off; sh → 0011 (off=0) or 1100 (off=2); sw → 1111. Loads → 1111.
- **Write data:** sb → {4{wd[7:0]}}, sh → {2{wd[15:0]}}, sw → wd.
- **FSM states:** IDLE, WAIT, DONE. Counter cnt is $clog2(TIMEOUT) bits wide.
  - IDLE, no memop: pass-through; stallM=0.
  - IDLE, memop misaligned: no request; stallM=1; next state DONE with err=01.
  - IDLE, memop aligned: dmem_req=1, stallM=1. If dmem_ack=1, capture dmem_rdata and go to DONE, err=00. Otherwise go to WAIT with cnt=1.
  - WAIT: dmem_req=1, stallM=1.
    - ack → capture rdata, go to DONE, err=00.
    - No ack and cnt==TIMEOUT-1 → go to DONE, err=10, captured word=0.
    - Otherwise cnt+1.
  - DONE: dmem_req=0, stallM=0; outputs reflect the completed op; memerrM=err. Next state is IDLE unconditionally.
- **readdata:**
  - In DONE for loads: the selected lane(s) of the captured word. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
  - Otherwise: 0.
- **Control outputs:**
  - regwriteM = regwriteM_in & validM & (err==00 in DONE, else 1).
  - memtoregM = memtoregM_in & validM.
- **Pass-through:** aluoutM, writeregM and instrM_o equal their inputs.
- **memerrM:** 00 outside DONE.
- **Upstream contract:** inputs remain stable while stallM=1, so dmem_addr, dmem_we, dmem_be and dmem_wdata are stable for the whole request.

## Timing
- **Reset** (asynchronous, rst_n=0): state=IDLE, cnt=0, err=00, captured word=0.
  - dmem_req=0 and memerrM=00 immediately.
  - stallM follows IDLE rules once rst_n=1.
- **Memop latency:** (request cycles) + 1 DONE cycle. Minimum 2 cycles (ack in the IDLE cycle), i.e. 1 stall cycle.
- **Misaligned op:** 2 cycles, 1 stall cycle.
- **Timeout:** exactly TIMEOUT request cycles, then DONE.
- **Non-memop:** 0 added cycles.
- **Ack outside a request:** dmem_ack while dmem_req=0 is ignored.
- **Ack in the last allowed request cycle:** ack in the cycle where cnt==TIMEOUT-1 is a success; ack wins over timeout.
- **Reset mid-WAIT:** the access is abandoned and no error is reported.
- **Back-to-back memops:** the second op is sampled in the IDLE cycle following DONE.

## Test plan
- **lw, delayed ack:** lw at 0x100; ack on 3rd request cycle with rdata 0x11223344 → stallM=1 for 3 cycles, dmem_addr=0x40, be=1111; DONE: readdata=0x11223344, regwriteM=1, memerrM=00.
- **lb/lbu extension:** lb at 0x103, word 0x80FF0000 → readdata=0xFFFFFF80. lbu at the same address → 0x00000080. lhu at 0x102 → 0x000080FF.
- **Stores:** sb at 0x202, wd=0x000000AB → dmem_we=1, be=0100, wdata=0xABABABAB. sh at 0x102, wd=0x1234 → be=1100, wdata=0x12341234.
- **Misaligned:** sh at 0x101 → dmem_req never high, 1 stall cycle; DONE: memerrM=01, regwriteM=0. lw at 0x102 → same response.
- **Timeout:** TIMEOUT=4, ack never asserted → dmem_req high exactly 4 cycles; DONE: memerrM=10, readdata=0, regwriteM=0. Repeat with ack in the 4th cycle → success.
- **Pass-through and reset:** add instruction (opcode 0) → stallM=0, outputs pass through, readdata=0. rst_n low during WAIT → dmem_req=0 immediately; after release, state=IDLE.
